arb_wrr_burst: RTL and testbench
================================

// Module: arb_wrr_burst
// PURPOSE
//  Weighted round-robin burst arbiter in front of a shared single-port resource.
//  - Grants one requester at a time and holds the grant for up to weight[i] accepted beats.
//  - Sits where the plain round-robin arbiter sits when requesters need unequal bandwidth.
//  - Grants are registered; yumi_i from the resource counts beats.
// PARAMETERS
//  NUM_REQUESTERS  4  number of requesters, >=2
//  WEIGHT_WIDTH    4  bits per weight; max burst = 2**WEIGHT_WIDTH-1 beats
// PORTS
//  clk_i         in   1                        clock, all state on posedge
//  reset_i       in   1                        reset; asynchronous and active-high
//  reqs_i        in   NUM_REQUESTERS           request per requester; hold until granted
//  cfg_v_i       in   1                        weight write strobe
//  cfg_id_i      in   $clog2(NUM_REQUESTERS)   requester index to write
//  cfg_weight_i  in   WEIGHT_WIDTH             new weight; 0 = requester disabled
//  yumi_i        in   1                        resource consumed one beat of the owner this cycle
//  v_o           out  1                        a grant is active
//  grants_o      out  NUM_REQUESTERS           one-hot grant, 0 when !v_o
//  grant_id_o    out  $clog2(NUM_REQUESTERS)   binary index of owner, 0 when !v_o
// BEHAVIOUR
//  Reset values
//  - v_o=0, grants_o=0, grant_id_o=0, state=IDLE.
//  - All weights=1, giving plain round-robin.
//  - last_r=NUM_REQUESTERS-1, so requester 0 has first priority.
//  Eligibility
//  - eligible = reqs_i & (weight!=0).
//  - Winner = first set bit of eligible, scanning from last_r+1 with mod-N wrap.
//  IDLE
//  - If |eligible, register the winner: next cycle state=BUSY, v_o=1, owner=winner.
//  - count_r loads weight[winner]; last_r loads the winner.
//  - Latency from request to grant = 1 cycle.
//  BUSY
//  - Each cycle with yumi_i=1, count_r decrements.
//  - Release when either holds:
//    (a) yumi_i && count_r==1;
//    (b) !reqs_i[owner], in which case any yumi_i in that cycle is still counted.
//  - On release with other |eligible: pick a new winner the same cycle (owner excluded unless it
//    is the only eligible one). Grant switches at the next edge with no idle bubble.
//  - On release with no eligible: go to IDLE; v_o=0 next cycle.
//  - yumi_i while !v_o is ignored.
//  Weights
//  - A cfg write lands at the edge and affects only future winner selection and count loads.
//  - A write to the current owner does not change the in-flight count_r.
//  - A write of 0 to the owner does not revoke its burst.
//  - A cfg write and a selection in the same cycle use the old weight.
//  count_r width = WEIGHT_WIDTH; it never underflows because release occurs at 1.
//  Reset asserted mid-burst: the grant drops immediately (async) and all weights return to 1.
//  Invariants
//  - $onehot0(grants_o).
//  - grants_o[i] implies reqs_i[i] was high in the previous cycle.
//  - Every eligible requester is granted within (NUM_REQUESTERS-1)*max_weight+1 cycles,
//    given yumi_i=1.
// STRUCTURE
//  Package arb_pkg
//  - typedef enum {IDLE,BUSY} arb_state_e.
//  - localparam ID_W = $clog2(NUM_REQUESTERS).
//  - function onehot_to_id.
//  Sub-module rr_pick (combinational)
//  - Inputs: eligible vector, last index.
//  - Outputs: found, winner id.
//  - Implemented by rotate, priority-encode, un-rotate.
//  Top level: FSM, count_r, last_r, weight register file.
// TESTING
//  1. Reset, reqs=4'b1111, all weights=1, yumi=1 -> grants 0001,0010,0100,1000,0001 on cycles 1-5.
//  2. weights={1,1,1,3} (req3..0), reqs=4'b1001, yumi=1 -> grants 0001,1000,1000,1000,0001.
//  3. Owner 2 with weight 4 drops reqs[2] after 2 yumis -> release next edge; req 3 granted,
//     no bubble.
//  4. cfg write weight[1]=0 while reqs=4'b0010 -> v_o stays 0.
//     Then write weight[1]=2 -> grant 0010 one cycle later.
//  5. Mid-burst reset_i pulse -> v_o=0 and grants_o=0 asynchronously; after release,
//     reqs=1111 grants 0001 first.
//  6. yumi=0 for 5 cycles with owner 0 (weight 2) -> grant held unchanged; then two yumis release.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    localparam int ARB_NUM_REQ  = 4;
    localparam int ARB_WEIGHT_W = 4;
    localparam int ID_W         = $clog2(ARB_NUM_REQ);

    // OR-reduce the set bit positions; exact for one-hot inputs.
    function automatic logic [31:0] onehot_to_id(input logic [31:0] oh);
        logic [31:0] id;
        id = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                id = id | 32'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate eligible so last_id+1 sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   eligible,
    input  logic [IDW-1:0] last_id,
    output logic           found,
    output logic [IDW-1:0] winner_id
);

    logic [N-1:0]   rot;
    logic [IDW-1:0] idx;
    int             start;
    int             k;

    always_comb begin
        rot       = '0;
        idx       = '0;
        k         = 0;
        start     = (int'(last_id) + 1) % N;
        for (int i = 0; i < N; i++) begin
            idx    = IDW'((start + i) % N);
            rot[i] = eligible[idx];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = i;
            end
        end
        found     = |rot;
        winner_id = IDW'((start + k) % N);
    end

endmodule

// File: rtl/arb_wrr_burst.sv
// Weighted round-robin burst arbiter: the owner keeps the grant for up
// to weight[owner] accepted beats, then ownership rotates without a bubble.
module arb_wrr_burst
    import arb_pkg::*;
#(
    parameter  int NUM_REQUESTERS = ARB_NUM_REQ,
    parameter  int WEIGHT_WIDTH   = ARB_WEIGHT_W,
    localparam int IDW            = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQUESTERS-1:0] reqs_i,
    input  logic                      cfg_v_i,
    input  logic [IDW-1:0]            cfg_id_i,
    input  logic [WEIGHT_WIDTH-1:0]   cfg_weight_i,
    input  logic                      yumi_i,
    output logic                      v_o,
    output logic [NUM_REQUESTERS-1:0] grants_o,
    output logic [IDW-1:0]            grant_id_o
);

    arb_state_e                state_r, state_n;
    logic [IDW-1:0]            owner_r, owner_n;
    logic [IDW-1:0]            last_r, last_n;
    logic [WEIGHT_WIDTH-1:0]   count_r, count_n;
    logic [WEIGHT_WIDTH-1:0]   weight_r [NUM_REQUESTERS];
    logic [NUM_REQUESTERS-1:0] eligible;
    logic                      found;
    logic [IDW-1:0]            winner;
    logic                      release_w;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            eligible[i] = reqs_i[i] && (weight_r[i] != '0);
        end
    end

    // Scanning from last_r+1 puts the current owner last, so it only
    // wins again when it is the sole eligible requester.
    rr_pick #(.N(NUM_REQUESTERS)) u_pick (
        .eligible  (eligible),
        .last_id   (last_r),
        .found     (found),
        .winner_id (winner)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            owner_r <= '0;
            last_r  <= IDW'(NUM_REQUESTERS - 1);
            count_r <= '0;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            last_r  <= last_n;
            count_r <= count_n;
        end
    end

    always_comb begin
        state_n   = state_r;
        owner_n   = owner_r;
        last_n    = last_r;
        count_n   = count_r;
        release_w = 1'b0;
        unique case (state_r)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    owner_n = winner;
                    last_n  = winner;
                    count_n = weight_r[winner];
                end
            end
            BUSY: begin
                release_w = (yumi_i && count_r == WEIGHT_WIDTH'(1))
                          || !reqs_i[owner_r];
                if (yumi_i) begin
                    count_n = count_r - WEIGHT_WIDTH'(1);
                end
                if (release_w) begin
                    if (found) begin
                        owner_n = winner;
                        last_n  = winner;
                        count_n = weight_r[winner];
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        v_o      = (state_r == BUSY);
        grants_o = '0;
        if (v_o) begin
            grants_o[owner_r] = 1'b1;
        end
        grant_id_o = IDW'(onehot_to_id(32'(grants_o)));
    end

    // Writes land at the edge, so a same-cycle selection sees the old weight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                weight_r[i] <= WEIGHT_WIDTH'(1);
            end
        end else if (cfg_v_i) begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (cfg_id_i == IDW'(i)) begin
                    weight_r[i] <= cfg_weight_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_arb_wrr_burst.sv
// Scoreboard bench for arb_wrr_burst: directed scenarios plus random
// traffic, all checked against a beat-counting reference model.
module tb_arb_wrr_burst;

    localparam int N  = 4;
    localparam int WW = 4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [N-1:0]  reqs_i;
    logic          cfg_v_i;
    logic [1:0]    cfg_id_i;
    logic [WW-1:0] cfg_weight_i;
    logic          yumi_i;
    logic          v_o;
    logic [N-1:0]  grants_o;
    logic [1:0]    grant_id_o;

    arb_wrr_burst #(.NUM_REQUESTERS(N), .WEIGHT_WIDTH(WW)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .reqs_i       (reqs_i),
        .cfg_v_i      (cfg_v_i),
        .cfg_id_i     (cfg_id_i),
        .cfg_weight_i (cfg_weight_i),
        .yumi_i       (yumi_i),
        .v_o          (v_o),
        .grants_o     (grants_o),
        .grant_id_o   (grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic         v;
        logic [N-1:0] g;
        logic [1:0]   id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    int   m_w [N];
    int   m_owner;
    int   m_rem;
    int   m_last;
    bit   served [N];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_w[i]    = 1;
            served[i] = 1'b0;
        end
        m_owner = -1;
        m_rem   = 0;
        m_last  = N - 1;
    endtask

    function automatic int pick(input logic [N-1:0] r);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (((r >> c) & 1) != 0 && m_w[c] != 0) begin
                return c;
            end
        end
        return -1;
    endfunction

    // Drive one cycle from a negedge, predict the post-edge grant, advance.
    task automatic step(input logic [N-1:0] r, input bit y, input bit cv,
                        input int cid, input int cw);
        exp_t e;
        int   p;
        reqs_i       = r;
        yumi_i       = y;
        cfg_v_i      = cv;
        cfg_id_i     = 2'(cid);
        cfg_weight_i = WW'(cw);
        if (m_owner < 0) begin
            p = pick(r);
            if (p >= 0) begin
                m_owner = p;
                m_rem   = m_w[p];
                m_last  = p;
            end
        end else begin
            if (y) m_rem--;
            if ((y && m_rem == 0) || ((r >> m_owner) & 1) == 0) begin
                p       = pick(r);
                m_owner = p;
                if (p >= 0) begin
                    m_rem  = m_w[p];
                    m_last = p;
                end
            end
        end
        if (cv) m_w[cid] = cw;
        e.v  = (m_owner >= 0);
        e.g  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        sb.push_back(e);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        reqs_i  = '0;
        yumi_i  = 1'b0;
        cfg_v_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();
    endtask

    always @(posedge clk_i) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("v_o", 32'(v_o), 32'(mon_e.v));
            check("grants_o", 32'(grants_o), 32'(mon_e.g));
            check("grant_id_o", 32'(grant_id_o), 32'(mon_e.id));
            check("onehot0", 32'($onehot0(grants_o)), 32'd1);
        end
    end

    logic [N-1:0] t1 [5];
    logic [N-1:0] t2 [5];
    logic [N-1:0] cur;
    logic         hi;
    int           cw;

    initial begin
        t1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t2 = '{4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
        reset_i      = 1'b1;
        reqs_i       = '0;
        yumi_i       = 1'b0;
        cfg_v_i      = 1'b0;
        cfg_id_i     = '0;
        cfg_weight_i = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check("reset_v", 32'(v_o), 32'd0);
        check("reset_grants", 32'(grants_o), 32'd0);
        check("reset_id", 32'(grant_id_o), 32'd0);
        reset_i = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1, 0, 0, 0);
            check("t1_rr", 32'(grants_o), 32'(t1[i]));
        end

        do_reset();
        step(4'b0000, 0, 1, 3, 3);
        for (int i = 0; i < 5; i++) begin
            step(4'b1001, 1, 0, 0, 0);
            check("t2_weight", 32'(grants_o), 32'(t2[i]));
        end

        do_reset();
        step(4'b0000, 0, 1, 2, 4);
        step(4'b1100, 1, 0, 0, 0);
        check("t3_owner2", 32'(grants_o), 32'b0100);
        step(4'b1100, 1, 0, 0, 0);
        step(4'b1100, 1, 0, 0, 0);
        step(4'b1000, 1, 0, 0, 0);
        check("t3_drop_switch", 32'(grants_o), 32'b1000);

        do_reset();
        step(4'b0000, 0, 1, 1, 0);
        repeat (3) step(4'b0010, 0, 0, 0, 0);
        check("t4_disabled", 32'(v_o), 32'd0);
        step(4'b0010, 0, 1, 1, 2);
        check("t4_old_weight", 32'(v_o), 32'd0);
        step(4'b0010, 0, 0, 0, 0);
        check("t4_enabled", 32'(grants_o), 32'b0010);

        do_reset();
        step(4'b0000, 0, 1, 0, 3);
        step(4'b1111, 1, 0, 0, 0);
        step(4'b1111, 0, 0, 0, 0);
        reset_i = 1'b1;
        #1;
        check("t5_async_v", 32'(v_o), 32'd0);
        check("t5_async_g", 32'(grants_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();
        step(4'b1111, 1, 0, 0, 0);
        check("t5_after_reset", 32'(grants_o), 32'b0001);

        do_reset();
        step(4'b0000, 0, 1, 0, 2);
        step(4'b0001, 0, 0, 0, 0);
        repeat (5) begin
            step(4'b0001, 0, 0, 0, 0);
            check("t6_hold", 32'(grants_o), 32'b0001);
        end
        step(4'b0011, 1, 0, 0, 0);
        check("t6_one_beat", 32'(grants_o), 32'b0001);
        step(4'b0011, 1, 0, 0, 0);
        check("t6_release", 32'(grants_o), 32'b0010);

        do_reset();
        cur = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                hi = cur[i];
                if (m_owner == i) begin
                    served[i] = 1'b1;
                    if ($urandom_range(7) == 0) begin
                        hi        = 1'b0;
                        served[i] = 1'b0;
                    end
                end else if (hi) begin
                    if (served[i] && $urandom_range(1) == 0) begin
                        hi        = 1'b0;
                        served[i] = 1'b0;
                    end
                end else if ($urandom_range(2) == 0) begin
                    hi = 1'b1;
                end
                cur[i] = hi;
            end
            cw = ($urandom_range(9) == 0) ? 15 : int'($urandom_range(4));
            step(cur, $urandom_range(3) != 0, $urandom_range(5) == 0,
                 int'($urandom_range(3)), cw);
        end

        @(posedge clk_i);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
